// File: rtl/edge_detect5.sv
// edge_detect5: 5x5 Laplacian-style edge detector on a line-buffer window.
// Computes |25*centre - sum(all 25 taps)|, compares it against iThresh and
// replaces the delayed RGB pixel with black when an edge is found.
// Three-stage pipeline; every stage advances only when clken is high.
// Optional feature macro: BORDER_MASK_EN adds position counters, iSof resync
// and masking of windows within two pixels of the frame edge.
module edge_detect5 #(
    parameter int p_bit_width_in = 8,
    parameter int p_width        = 640,
    parameter int p_height       = 480
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clken,
    input  logic                            iSof,
    input  logic [25*p_bit_width_in-1:0]    iGrid,
    input  logic [23:0]                     iPixel,
    input  logic [p_bit_width_in+5:0]       iThresh,
    output logic [23:0]                     oPixel,
    output logic                            oEdge,
    output logic                            oValid
);

    localparam int lp_w = p_bit_width_in;

    logic [lp_w-1:0]        w_tap [25];
    logic [lp_w+2:0]        w_row_sum [5];
    logic [lp_w+4:0]        w_c25;
    logic [lp_w+4:0]        w_total;
    logic [lp_w+5:0]        w_mag;
    logic                   w_border2;

    logic [lp_w+2:0]        r_row_sum [5];
    logic [lp_w+4:0]        r_c25;
    logic [23:0]            r_pix1;
    logic [23:0]            r_pix2;
    logic signed [lp_w+5:0] r_diff;
    logic [1:0]             r_fill;
    logic [23:0]            r_pixel;
    logic                   r_edge;
    logic                   r_valid;

    // Slice the packed window into taps; tap 0 sits in the top bits.
    always_comb begin
        for (int k = 0; k < 25; k++) begin
            w_tap[k] = iGrid[(25-k)*lp_w-1 -: lp_w];
        end
    end

    // Per-row sums of five taps each (W+3 bits cannot overflow).
    always_comb begin
        for (int r = 0; r < 5; r++) begin
            w_row_sum[r] = '0;
            for (int c = 0; c < 5; c++) begin
                w_row_sum[r] = w_row_sum[r] + {3'b000, w_tap[5*r+c]};
            end
        end
    end

    // 25*centre built as 16c + 8c + c to avoid a generic multiplier.
    assign w_c25 = {1'b0, w_tap[12], 4'b0000}
                 + {2'b00, w_tap[12], 3'b000}
                 + {5'b00000, w_tap[12]};

    assign w_total = {2'b00, r_row_sum[0]} + {2'b00, r_row_sum[1]}
                   + {2'b00, r_row_sum[2]} + {2'b00, r_row_sum[3]}
                   + {2'b00, r_row_sum[4]};

`ifdef BORDER_MASK_EN
    localparam int lp_cw = $clog2(p_width);
    localparam int lp_rw = $clog2(p_height);

    logic [lp_cw-1:0] r_col;
    logic [lp_rw-1:0] r_row;
    logic [lp_cw-1:0] r_tag_col;
    logic [lp_rw-1:0] r_tag_row;
    logic [lp_cw-1:0] w_col_nxt;
    logic [lp_rw-1:0] w_row_nxt;
    logic [lp_cw-1:0] w_tag_col;
    logic [lp_rw-1:0] w_tag_row;
    logic             w_border1;
    logic             r_border2;

    // Position tag for the incoming window and the counter advance; iSof resyncs.
    always_comb begin
        if (iSof) begin
            w_tag_col = '0;
            w_tag_row = '0;
            w_col_nxt = lp_cw'(1);
            w_row_nxt = '0;
        end else begin
            w_tag_col = r_col;
            w_tag_row = r_row;
            if (r_col == lp_cw'(p_width - 1)) begin
                w_col_nxt = '0;
                if (r_row == lp_rw'(p_height - 1)) begin
                    w_row_nxt = '0;
                end else begin
                    w_row_nxt = r_row + lp_rw'(1);
                end
            end else begin
                w_col_nxt = r_col + lp_cw'(1);
                w_row_nxt = r_row;
            end
        end
    end

    // Position counters and stage-1 tag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_tag_col <= '0;
            r_tag_row <= '0;
        end else if (clken) begin
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_tag_col <= w_tag_col;
            r_tag_row <= w_tag_row;
        end
    end

    assign w_border1 = (r_tag_col < lp_cw'(2)) | (r_tag_col > lp_cw'(p_width - 3))
                     | (r_tag_row < lp_rw'(2)) | (r_tag_row > lp_rw'(p_height - 3));

    // Carry the border flag alongside the stage-2 difference.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_border2 <= 1'b0;
        end else if (clken) begin
            r_border2 <= w_border1;
        end
    end

    assign w_border2 = r_border2;
`else
    logic w_unused_sof;
    assign w_unused_sof = iSof;
    assign w_border2    = 1'b0;
`endif

    // Stage 1: row sums, scaled centre and the aligned RGB pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 5; r++) begin
                r_row_sum[r] <= '0;
            end
            r_c25  <= '0;
            r_pix1 <= '0;
        end else if (clken) begin
            for (int r = 0; r < 5; r++) begin
                r_row_sum[r] <= w_row_sum[r];
            end
            r_c25  <= w_c25;
            r_pix1 <= iPixel;
        end
    end

    // Stage 2: signed difference between scaled centre and window total.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_diff <= '0;
            r_pix2 <= '0;
        end else if (clken) begin
            r_diff <= $signed({1'b0, r_c25}) - $signed({1'b0, w_total});
            r_pix2 <= r_pix1;
        end
    end

    // Magnitude of the difference; |diff| always fits in W+6 bits unsigned.
    always_comb begin
        if (r_diff[lp_w+5]) begin
            w_mag = $unsigned(-r_diff);
        end else begin
            w_mag = $unsigned(r_diff);
        end
    end

    // Stage 3: threshold (strictly greater), border mask and pixel select.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge  <= 1'b0;
            r_pixel <= '0;
        end else if (clken) begin
            if ((w_mag > iThresh) && !w_border2) begin
                r_edge  <= 1'b1;
                r_pixel <= 24'h000000;
            end else begin
                r_edge  <= 1'b0;
                r_pixel <= r_pix2;
            end
        end
    end

    // Fill counter suppresses strobes until the pipeline holds real data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fill  <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= clken && (r_fill >= 2'd2);
            if (clken && (r_fill != 2'd3)) begin
                r_fill <= r_fill + 2'd1;
            end
        end
    end

    assign oPixel = r_pixel;
    assign oEdge  = r_edge;
    assign oValid = r_valid;

endmodule

// File: tb/tb_edge_detect5.sv
// Directed, table-driven bench for edge_detect5 on a reduced 32x8 frame.
// Border expectations follow BORDER_MASK_EN when the bench is built with it.
module tb_edge_detect5;

    localparam int W  = 8;
    localparam int PW = 32;
    localparam int PH = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           clken;
    logic           iSof;
    logic [199:0]   iGrid;
    logic [23:0]    iPixel;
    logic [13:0]    iThresh;
    logic [23:0]    oPixel;
    logic           oEdge;
    logic           oValid;

    edge_detect5 #(.p_bit_width_in(W), .p_width(PW), .p_height(PH)) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken), .iSof(iSof),
        .iGrid(iGrid), .iPixel(iPixel), .iThresh(iThresh),
        .oPixel(oPixel), .oEdge(oEdge), .oValid(oValid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [199:0] grid;
        logic [23:0]  pix;
        logic [13:0]  th;
        logic         raw;
    } vec_t;

    typedef struct {
        logic [23:0] pix;
        logic [13:0] th;
        logic        raw;
        logic        brd;
        logic        tagd;
    } item_t;

    item_t pipe[$];
    int    n_pass  = 0;
    int    n_total = 0;
    int    m_col   = 0;
    int    m_row   = 0;
    int    edge_count = 0;

    function automatic logic [199:0] mkgrid(input logic [7:0] c, input logic [7:0] o);
        logic [199:0] g;
        for (int k = 0; k < 25; k++) g[(25-k)*8-1 -: 8] = (k == 12) ? c : o;
        return g;
    endfunction

    function automatic logic [199:0] mkramp();
        logic [199:0] g;
        for (int k = 0; k < 25; k++) g[(25-k)*8-1 -: 8] = 8'(10*k);
        return g;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One clken-qualified cycle; checks the window that reaches the output.
    task automatic push(input logic [199:0] g, input logic [23:0] p, input logic [13:0] th,
                        input logic raw, input logic sof, input logic tagd);
        item_t it;
        int tc, tr;
        logic exp_e;
        if (sof) begin
            tc = 0; tr = 0; m_col = 1; m_row = 0;
        end else begin
            tc = m_col; tr = m_row;
            if (m_col == PW-1) begin
                m_col = 0;
                m_row = (m_row == PH-1) ? 0 : m_row + 1;
            end else m_col = m_col + 1;
        end
        it.pix = p; it.th = th; it.raw = raw; it.tagd = tagd;
`ifdef BORDER_MASK_EN
        it.brd = (tc < 2) || (tc > PW-3) || (tr < 2) || (tr > PH-3);
`else
        it.brd = 1'b0;
`endif
        pipe.push_back(it);
        iThresh = (pipe.size() == 3) ? pipe[0].th : 14'd0;
        iGrid = g; iPixel = p; iSof = sof; clken = 1'b1;
        @(posedge clk); #1;
        if (pipe.size() == 3) begin
            it = pipe.pop_front();
            exp_e = it.raw & ~it.brd;
            chk("valid", {31'd0, oValid}, 32'd1);
            chk("edge", {31'd0, oEdge}, {31'd0, exp_e});
            chk("pixel", {8'd0, oPixel}, exp_e ? 32'd0 : {8'd0, it.pix});
            if (it.tagd && oEdge) edge_count++;
        end else begin
            chk("fill_valid", {31'd0, oValid}, 32'd0);
        end
    endtask

    // One stalled cycle: outputs must hold and no strobe.
    task automatic idle();
        logic [23:0] pp;
        logic        pe;
        pp = oPixel; pe = oEdge;
        clken = 1'b0; iSof = 1'($urandom_range(0, 1));
        iGrid = mkgrid(8'($urandom), 8'($urandom)); iPixel = 24'($urandom);
        @(posedge clk); #1;
        chk("stall_valid", {31'd0, oValid}, 32'd0);
        chk("stall_edge", {31'd0, oEdge}, {31'd0, pe});
        chk("stall_pixel", {8'd0, oPixel}, {8'd0, pp});
    endtask

    vec_t vt[13];
    logic [199:0] flat;
    logic [199:0] bright;

    initial begin
        flat   = mkgrid(8'h50, 8'h50);
        bright = mkgrid(8'hFF, 8'h00);
        vt[0]  = '{flat,                      24'h123456, 14'd64,    1'b0};
        vt[1]  = '{bright,                    24'h0A0B0C, 14'd64,    1'b1};
        vt[2]  = '{mkgrid(8'h00, 8'h10),      24'h111111, 14'd383,   1'b1};
        vt[3]  = '{mkgrid(8'h00, 8'h10),      24'h222222, 14'd384,   1'b0};
        vt[4]  = '{bright,                    24'h333333, 14'd6119,  1'b1};
        vt[5]  = '{bright,                    24'h444444, 14'd6120,  1'b0};
        vt[6]  = '{mkgrid(8'hFF, 8'hFF),      24'h555555, 14'd0,     1'b0};
        vt[7]  = '{mkgrid(8'h10, 8'h00),      24'h666666, 14'd383,   1'b1};
        vt[8]  = '{mkgrid(8'h00, 8'hFF),      24'h777777, 14'd6119,  1'b1};
        vt[9]  = '{mkgrid(8'h80, 8'h7F),      24'h888888, 14'd23,    1'b1};
        vt[10] = '{mkgrid(8'h80, 8'h7F),      24'h999999, 14'd24,    1'b0};
        vt[11] = '{mkramp(),                  24'hABCDEF, 14'd0,     1'b0};
        vt[12] = '{bright,                    24'hFEDCBA, 14'h3FFF,  1'b0};

        // Reset held with random inputs and clken high: outputs stay zero.
        reset_n = 1'b0; clken = 1'b1; iSof = 1'b0; iThresh = 14'd0;
        iGrid = '0; iPixel = '0;
        for (int i = 0; i < 4; i++) begin
            iGrid = mkgrid(8'($urandom), 8'($urandom)); iPixel = 24'($urandom);
            iSof = 1'($urandom_range(0, 1)); iThresh = 14'($urandom);
            @(posedge clk); #1;
            chk("rst_out", {7'd0, oValid, oEdge, oPixel}, 32'd0);
        end
        reset_n = 1'b1;

        // Move to interior position (2,2) with flat windows, then run the table.
        push(flat, 24'hA00000, 14'h3FFF, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 66; i++) push(flat, 24'hA00000 + 24'(i), 14'h3FFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) push(vt[i].grid, vt[i].pix, vt[i].th, vt[i].raw, 1'b0, 1'b0);

        // Stall pattern 1,0,0,1 with order preserved through the pipeline.
        push(flat, 24'hC0FFEE, 14'd64, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        push(bright, 24'hBEEF01, 14'd64, 1'b1, 1'b0, 1'b0);
        push(flat, 24'h0D0D0D, 14'd64, 1'b0, 1'b0, 1'b0);
        idle();
        push(flat, 24'h0E0E0E, 14'd64, 1'b0, 1'b0, 1'b0);
        push(flat, 24'h0F0F0F, 14'd64, 1'b0, 1'b0, 1'b0);

        // Full frame of bright points from iSof; interior count is hand-computed.
        edge_count = 0;
        push(bright, 24'h000001, 14'd64, 1'b1, 1'b1, 1'b1);
        for (int i = 1; i < PW*PH; i++) push(bright, 24'(i + 1), 14'd64, 1'b1, 1'b0, 1'b1);
        // Continue without iSof: row wraps to 0 and (2,2) of the next frame is interior.
        for (int i = 0; i < 70; i++) push(bright, 24'h100000 + 24'(i), 14'd64, 1'b1, 1'b0, 1'b0);
`ifdef BORDER_MASK_EN
        chk("frame_edges", edge_count, (PW-4)*(PH-4));
`else
        chk("frame_edges", edge_count, PW*PH);
`endif

        // Asynchronous reset mid-line; outputs clear without a clock edge.
        push(flat, 24'h5A5A5A, 14'd64, 1'b0, 1'b0, 1'b0);
        clken = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk("async_rst", {7'd0, oValid, oEdge, oPixel}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        pipe.delete(); m_col = 0; m_row = 0;
        push(flat, 24'h010203, 14'd64, 1'b0, 1'b0, 1'b0);
        push(flat, 24'h040506, 14'd64, 1'b0, 1'b0, 1'b0);
        push(flat, 24'h070809, 14'd64, 1'b0, 1'b0, 1'b0);
        push(flat, 24'h0A0B0C, 14'd64, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
